// File: rtl/fa_str_pkg.sv
// fa_str_pkg: shared operand type and BIST constants for the fa_str full adder
package fa_str_pkg;
   typedef struct packed {
      logic a;
      logic b;
      logic c;
   } op_t;
   localparam logic [2:0] VEC_LAST = 3'b111;
endpackage

// File: rtl/fa_str_half_adder.sv
// half_adder: gate-level half adder building block
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// File: rtl/fa_str.sv
// fa_str: structural full adder with registered outputs, behavioural cross-check
// and a built-in 3-bit vector sweep
module fa_str
   import fa_str_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             c_in,
   input  logic             bist_en,
   input  logic             fault_inj,
   output logic             sum,
   output logic             c_out,
   output logic             sum_q,
   output logic             c_out_q,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [2:0]       bist_vec,
   output logic             bist_done
);
   op_t        op;
   logic       s1, c1, s2, c2;
   logic [1:0] ref_sc;
   logic       mismatch;
   assign op = bist_en ? op_t'(bist_vec) : op_t'({a, b, c_in});
   half_adder u_ha1 (.a(op.a), .b(op.b), .s(s1), .c(c1));
   half_adder u_ha2 (.a(s1), .b(op.c), .s(s2), .c(c2));
   or u_or (c_out, c1, c2);
   assign sum = s2 ^ fault_inj;
   // reference adder is arithmetic so it cannot share a netlist bug with the gates
   assign ref_sc   = 2'(op.a) + 2'(op.b) + 2'(op.c);
   assign mismatch = (sum != ref_sc[0]) || (c_out != ref_sc[1]);
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q     <= 1'b0;
         c_out_q   <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= '0;
         bist_vec  <= 3'b000;
         bist_done <= 1'b0;
      end else begin
         sum_q   <= sum;
         c_out_q <= c_out;
         err     <= mismatch;
         if (mismatch && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
         if (bist_en) begin
            bist_vec <= bist_vec + 3'd1;
            if (bist_vec == VEC_LAST) bist_done <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fa_str.sv
// tb_fa_str: randomized + directed scoreboard bench for fa_str against an arithmetic model
module tb_fa_str;
   logic clk = 1'b0;
   logic rst = 1'b1, a = 1'b0, b = 1'b0, c_in = 1'b0, bist_en = 1'b0, fault_inj = 1'b0;
   logic sum, c_out, sum_q, c_out_q, err, bist_done;
   logic sum2, c_out2, sum_q2, c_out_q2, err2, bist_done2;
   logic [7:0] err_cnt;
   logic [1:0] err_cnt2;
   logic [2:0] bist_vec, bist_vec2;

   fa_str dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .bist_en(bist_en), .fault_inj(fault_inj),
      .sum(sum), .c_out(c_out), .sum_q(sum_q), .c_out_q(c_out_q), .err(err),
      .err_cnt(err_cnt), .bist_vec(bist_vec), .bist_done(bist_done)
   );
   fa_str #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .bist_en(bist_en), .fault_inj(fault_inj),
      .sum(sum2), .c_out(c_out2), .sum_q(sum_q2), .c_out_q(c_out_q2), .err(err2),
      .err_cnt(err_cnt2), .bist_vec(bist_vec2), .bist_done(bist_done2)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sum, cout, sumq, coutq, err, vec, done, cnt8, cnt2;
   } exp_t;
   exp_t sb[$];

   int total = 0, bad = 0;
   int m_sumq = 0, m_coutq = 0, m_err = 0, m_vec = 0, m_done = 0, m_mis = 0;

   // issue one cycle of stimulus; expectations for this cycle go to the scoreboard
   task automatic cycle(input int r, input int en, input int f, input int v);
      exp_t e;
      int op, s, ref_sum, ref_cout, mis;
      rst = r[0]; bist_en = en[0]; fault_inj = f[0];
      {a, b, c_in} = 3'(v);
      op = en ? m_vec : v;
      s = (op >> 2 & 1) + (op >> 1 & 1) + (op & 1);
      ref_sum = s % 2;
      ref_cout = s / 2;
      e.sum = ref_sum ^ f;
      e.cout = ref_cout;
      e.sumq = m_sumq; e.coutq = m_coutq; e.err = m_err; e.vec = m_vec; e.done = m_done;
      e.cnt8 = m_mis > 255 ? 255 : m_mis;
      e.cnt2 = m_mis > 3 ? 3 : m_mis;
      sb.push_back(e);
      mis = (e.sum != ref_sum || e.cout != ref_cout) ? 1 : 0;
      if (r) begin
         m_sumq = 0; m_coutq = 0; m_err = 0; m_vec = 0; m_done = 0; m_mis = 0;
      end else begin
         m_sumq = e.sum; m_coutq = e.cout; m_err = mis; m_mis += mis;
         if (en) begin
            if (m_vec == 7) m_done = 1;
            m_vec = (m_vec + 1) % 8;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sum", int'(sum), e.sum);
            chk("c_out", int'(c_out), e.cout);
            chk("sum_q", int'(sum_q), e.sumq);
            chk("c_out_q", int'(c_out_q), e.coutq);
            chk("err", int'(err), e.err);
            chk("err_cnt", int'(err_cnt), e.cnt8);
            chk("err_cnt_w2", int'(err_cnt2), e.cnt2);
            chk("err_w2", int'(err2), e.err);
            chk("bist_vec", int'(bist_vec), e.vec);
            chk("bist_done", int'(bist_done), e.done);
         end
      end
   end

   initial begin : driver
      @(posedge clk);
      #1;
      cycle(1, 0, 0, 0);
      for (int v = 0; v < 8; v++) cycle(0, 0, 0, v);
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, $urandom_range(0, 7));
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 7);
      cycle(0, 0, 1, 3);
      cycle(0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 1, $urandom_range(0, 7));
      cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 1, i < 2 ? 1 : 0, 0);
      cycle(1, 1, 1, 7);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 7);
      cycle(0, 0, 0, 0);
      for (int i = 0; i < 300; i++)
         cycle($urandom_range(0, 39) == 0 ? 1 : 0, $urandom_range(0, 1),
               $urandom_range(0, 3) == 0 ? 1 : 0, $urandom_range(0, 7));
      repeat (3) @(posedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fa_str.md
FA_STR -- requirements
Module: fa_str

Interface
REQ-001 Parameter: CNT_W, default 8, width of the mismatch counter (legal range 2..16).
REQ-002 Port: clk  input  1  single rising-edge clock for all registers.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: a  input  1  addend bit A (external operand).
REQ-005 Port: b  input  1  addend bit B (external operand).
REQ-006 Port: c_in  input  1  carry-in (external operand).
REQ-007 Port: bist_en  input  1  1 = internal 3-bit vector counter drives operands instead of a/b/c_in.
REQ-008 Port: fault_inj  input  1  test hook; 1 inverts the structural sum output only.
REQ-009 Port: sum  output  1  combinational structural sum of selected operands.
REQ-010 Port: c_out  output  1  combinational structural carry-out of selected operands.
REQ-011 Port: sum_q  output  1  sum registered on clk.
REQ-012 Port: c_out_q  output  1  c_out registered on clk.
REQ-013 Port: err  output  1  registered mismatch flag.
REQ-014 Port: err_cnt  output  CNT_W  saturating count of mismatching cycles.
REQ-015 Port: bist_vec  output  3  current internal vector {a,b,c_in}.
REQ-016 Port: bist_done  output  1  sticky; all 8 vectors checked.

Function
REQ-017 Operand select: {opa,opb,opc} = bist_en ? bist_vec : {a,b,c_in}, purely combinational.
REQ-018 Structural path: HA1(opa,opb) -> s1,c1; HA2(s1,opc) -> s2,c2; sum = s2 ^ fault_inj; c_out = c1 | c2.
REQ-019 Reference path: behavioural {ref_c,ref_s} = opa + opb + opc (2-bit result), independent of the gate netlist.
REQ-020 mismatch = (sum != ref_s) || (c_out != ref_c), combinational, internal.
REQ-021 Each posedge: sum_q <= sum, c_out_q <= c_out, err <= mismatch (one-cycle latency, err reflects operands of the previous cycle).
REQ-022 Each posedge with mismatch = 1: err_cnt increments by 1; saturates at 2^CNT_W-1, no wrap.
REQ-023 Each posedge with bist_en = 1: bist_vec increments by 1, wraps 3'b111 -> 3'b000; bist_en = 0 holds bist_vec.
REQ-024 bist_done sets on the posedge where bist_en = 1 and bist_vec = 3'b111; stays set until reset.
REQ-025 Toggling bist_en mid-sequence neither clears bist_vec nor bist_done.
REQ-026 No X-propagation dependence: outputs defined for all 8 operand combinations; fault_inj never affects ref path or c_out.

Reset
REQ-027 On posedge clk with rst = 1: sum_q = 0, c_out_q = 0, err = 0, err_cnt = 0, bist_vec = 3'b000, bist_done = 0.
REQ-028 rst has priority over every register update in the same cycle, including a concurrent mismatch or vector wrap.
REQ-029 sum and c_out stay combinational and valid during reset.

Structure
REQ-030 One sub-module half_adder (ports a, b, s, c; s = a^b, c = a&b), instantiated twice; carry OR is a primitive gate at top level.
REQ-031 No shared package required; CNT_W is a local parameter of fa_str only.
REQ-032 Reference model is inline behavioural logic in fa_str, not a sub-module.

Verification
REQ-033 Exhaustive external: bist_en = 0, fault_inj = 0, apply {a,b,c_in} = 000..111 -> {c_out,sum} = 00,01,01,10,01,10,10,11; err = 0 every cycle; err_cnt = 0.
REQ-034 BIST sweep: after reset, bist_en = 1 for 8 cycles -> bist_vec 0..7 then 0, bist_done = 1 after 8th edge, err_cnt = 0.
REQ-035 Fault injection: fault_inj = 1, {a,b,c_in} = 011 -> sum = 1, c_out = 1; next edge err = 1, err_cnt = 1.
REQ-036 Saturation: CNT_W = 2, fault_inj = 1 held for 6 cycles -> err_cnt = 3 thereafter.
REQ-037 Reset mid-run: rst = 1 asserted while bist_vec = 5, bist_done = 1, err_cnt = 2 -> next edge all registered outputs 0.
REQ-038 Registered latency: {a,b,c_in} changes 000 -> 111 before edge N -> sum_q = 1, c_out_q = 1 after edge N, not before.
